// File: rtl/sd_cmd_responder.sv
// ---------------------------------------------------------------------------
// sd_cmd_responder
//   Card-side responder for the SD CMD line, running on sdClk. Receives
//   48-bit host command frames, checks the transmission bit, CRC7 and end
//   bit, hands index/argument to local card logic, and then serializes the
//   48-bit (R1/R3) or 136-bit (R2) response supplied by that logic with the
//   required NCR spacing. Used for loopback bring-up of the uSD host path.
//
// Parameters
//   NCR       minimum cycles from command end bit to response start bit
//   NCR_MAX   cycles after the end bit after which an unanswered command
//             times out
//
// Ports
//   sdClk       in   SD clock, all logic on the rising edge
//   sysRstN     in   asynchronous active-low reset
//   sdCmdIn     in   CMD line input
//   sdCmdOut    out  CMD line drive value (1 whenever sdCmdEn=0)
//   sdCmdEn     out  CMD output enable
//   cmdValid    out  one-cycle pulse, received command fields valid
//   cmdIndex    out  received command index (held until next cmdValid)
//   cmdArg      out  received argument (held until next cmdValid)
//   cmdCrcErr   out  qualifies cmdValid: CRC7 mismatch or end bit 0
//   rspReady    out  high while waiting for a response from local logic
//   rspValid    in   response request, accepted on rspValid & rspReady
//   rspType     in   0 none, 1 R1-style, 2 R3, 3 R2 (136-bit)
//   rspData     in   R1/R3 payload in [31:0], R2 CID/CSD in [127:8]
//   rspTimeout  out  one-cycle pulse, no response accepted in time
//   busy        out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module sd_cmd_responder #(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         sdClk,
    input  logic         sysRstN,
    input  logic         sdCmdIn,
    output logic         sdCmdOut,
    output logic         sdCmdEn,
    output logic         cmdValid,
    output logic [5:0]   cmdIndex,
    output logic [31:0]  cmdArg,
    output logic         cmdCrcErr,
    output logic         rspReady,
    input  logic         rspValid,
    input  logic [1:0]   rspType,
    input  logic [127:0] rspData,
    output logic         rspTimeout,
    output logic         busy
);

    localparam int WW = $clog2(NCR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_WAIT,
        S_DLY,
        S_TX,
        S_END
    } state_t;

    state_t         r_state;
    logic [7:0]     r_bitn;     // index of the frame bit handled at this edge
    logic [6:0]     r_crc;      // running CRC7 (shared by RX and TX)
    logic [44:0]    r_rxsr;     // received bits 45..1
    logic           r_arm;      // start detection enabled (IDLE for >1 cycle)
    logic [WW-1:0]  r_wcnt;     // cycles since the end bit was sampled
    logic [1:0]     r_rtype;
    logic [127:0]   r_rdata;
    logic [135:0]   r_txsr;     // remaining TX bits, next bit at [135]
    logic           r_gencrc;   // CRC field comes from r_crc (not R3)
    logic           r_isr2;     // 136-bit frame, CRC window starts at bit 127

    logic           r_out;
    logic           r_en;
    logic           r_valid;
    logic [5:0]     r_idx;
    logic [31:0]    r_arg;
    logic           r_err;
    logic           r_tmo;

    logic           w_hs;
    logic [6:0]     w_rx_crc;
    logic           w_rx_err;
    logic [1:0]     w_ld_type;
    logic [127:0]   w_ld_data;
    logic [135:0]   w_frame;
    logic           w_load;
    logic           w_ncr_ok;
    logic           w_tx_bit;
    logic           w_tx_inwin;

    // CRC7, polynomial x^7 + x^3 + 1, one bit MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign w_hs     = rspValid && (r_state == S_WAIT);
    assign w_rx_crc = crc7_step(r_crc, sdCmdIn);
    // Evaluated when the end bit is on the line: r_rxsr[6:0] is the CRC field
    assign w_rx_err = (r_rxsr[6:0] != r_crc) || !sdCmdIn;
    assign w_ncr_ok = (r_wcnt >= WW'(NCR - 1));

    // In WAIT the response comes straight from the handshake inputs so the
    // start bit can go out on the handshake edge; in DLY it is the latched copy.
    assign w_ld_type = (r_state == S_WAIT) ? rspType : r_rtype;
    assign w_ld_data = (r_state == S_WAIT) ? rspData : r_rdata;

    assign w_load = ((r_state == S_WAIT) && w_hs && (rspType != 2'd0) && w_ncr_ok) ||
                    ((r_state == S_DLY) && w_ncr_ok);

    // Full response frame, left-aligned; CRC field is zero when the CRC
    // is generated on the fly during TX.
    always_comb begin
        w_frame = '0;
        case (w_ld_type)
            2'd1:    w_frame = {2'b00, r_idx, w_ld_data[31:0], 7'h00, 1'b1, 88'h0};
            2'd2:    w_frame = {2'b00, 6'h3F, w_ld_data[31:0], 7'h7F, 1'b1, 88'h0};
            2'd3:    w_frame = {2'b00, 6'h3F, w_ld_data[127:8], 7'h00, 1'b1};
            default: w_frame = '0;
        endcase
    end

    // Bits 7..1 of a generated-CRC frame come from the running CRC, MSB first
    assign w_tx_bit   = (r_gencrc && (r_bitn >= 8'd1) && (r_bitn <= 8'd7)) ?
                        r_crc[r_bitn[2:0] - 3'd1] : r_txsr[135];
    assign w_tx_inwin = (r_bitn >= 8'd8) && (!r_isr2 || (r_bitn <= 8'd127));

    always_ff @(posedge sdClk or negedge sysRstN) begin
        if (!sysRstN) begin
            r_state  <= S_IDLE;
            r_bitn   <= '0;
            r_crc    <= '0;
            r_rxsr   <= '0;
            r_arm    <= 1'b1;
            r_wcnt   <= '0;
            r_rtype  <= '0;
            r_rdata  <= '0;
            r_txsr   <= '0;
            r_gencrc <= 1'b0;
            r_isr2   <= 1'b0;
            r_out    <= 1'b1;
            r_en     <= 1'b0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_arg    <= '0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
            // A start bit on the first IDLE cycle after leaving another state
            // is ignored.
            r_arm   <= (r_state == S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (r_arm && !sdCmdIn) begin
                        r_state <= S_RX;
                        r_bitn  <= 8'd46;
                        r_crc   <= '0;   // start bit 0 leaves a zero CRC unchanged
                    end
                end

                S_RX: begin
                    r_rxsr <= {r_rxsr[43:0], sdCmdIn};
                    r_bitn <= r_bitn - 8'd1;
                    if (r_bitn >= 8'd8)
                        r_crc <= w_rx_crc;
                    if ((r_bitn == 8'd46) && !sdCmdIn) begin
                        r_state <= S_IDLE;
                    end else if (r_bitn == 8'd0) begin
                        r_valid <= 1'b1;
                        r_idx   <= r_rxsr[44:39];
                        r_arg   <= r_rxsr[38:7];
                        r_err   <= w_rx_err;
                        r_wcnt  <= WW'(1);
                        r_state <= w_rx_err ? S_IDLE : S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (w_hs) begin
                        r_rtype <= rspType;
                        r_rdata <= rspData;
                        r_wcnt  <= r_wcnt + WW'(1);
                        if (rspType == 2'd0)
                            r_state <= S_IDLE;
                        else
                            r_state <= S_DLY;   // overridden by w_load below
                    end else if (r_wcnt == WW'(NCR_MAX - 1)) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + WW'(1);
                    end
                end

                S_DLY: begin
                    r_wcnt <= r_wcnt + WW'(1);
                end

                S_TX: begin
                    r_out  <= w_tx_bit;
                    r_txsr <= {r_txsr[134:0], 1'b0};
                    r_bitn <= r_bitn - 8'd1;
                    if (w_tx_inwin)
                        r_crc <= crc7_step(r_crc, r_txsr[135]);
                    if (r_bitn == 8'd0)
                        r_state <= S_END;
                end

                S_END: begin
                    r_en    <= 1'b0;
                    r_out   <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase

            // Start bit goes out on this edge; the rest of the frame is
            // shifted from r_txsr, bit L-2 first.
            if (w_load) begin
                r_state  <= S_TX;
                r_en     <= 1'b1;
                r_out    <= 1'b0;
                r_txsr   <= {w_frame[134:0], 1'b0};
                r_bitn   <= (w_ld_type == 2'd3) ? 8'd134 : 8'd46;
                r_crc    <= '0;
                r_gencrc <= (w_ld_type != 2'd2);
                r_isr2   <= (w_ld_type == 2'd3);
            end
        end
    end

    assign sdCmdOut   = r_out | ~r_en;
    assign sdCmdEn    = r_en;
    assign cmdValid   = r_valid;
    assign cmdIndex   = r_idx;
    assign cmdArg     = r_arg;
    assign cmdCrcErr  = r_err;
    assign rspReady   = (r_state == S_WAIT);
    assign rspTimeout = r_tmo;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_responder
//   Self-checking bench for sd_cmd_responder. Fixed vectors from known SD
//   frames, a hand-written dead-cycle / framing / reset sequence, and random
//   transactions checked against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_sd_cmd_responder;

    localparam int NCR     = 2;
    localparam int NCR_MAX = 64;

    logic         sdClk = 1'b0;
    logic         sysRstN = 1'b0;
    logic         sdCmdIn = 1'b1;
    logic         rspValid = 1'b0;
    logic [1:0]   rspType = 2'd0;
    logic [127:0] rspData = '0;
    logic         sdCmdOut, sdCmdEn, cmdValid, cmdCrcErr, rspReady, rspTimeout, busy;
    logic [5:0]   cmdIndex;
    logic [31:0]  cmdArg;

    int    n_chk = 0;
    int    n_fail = 0;
    string tag = "init";

    sd_cmd_responder #(.NCR(NCR), .NCR_MAX(NCR_MAX)) dut (
        .sdClk(sdClk), .sysRstN(sysRstN), .sdCmdIn(sdCmdIn),
        .sdCmdOut(sdCmdOut), .sdCmdEn(sdCmdEn), .cmdValid(cmdValid),
        .cmdIndex(cmdIndex), .cmdArg(cmdArg), .cmdCrcErr(cmdCrcErr),
        .rspReady(rspReady), .rspValid(rspValid), .rspType(rspType),
        .rspData(rspData), .rspTimeout(rspTimeout), .busy(busy)
    );

    always #5 sdClk = ~sdClk;

    // Released line must read 1
    always @(negedge sdClk) begin
        if (sysRstN) begin
            n_chk++;
            if (!sdCmdEn && sdCmdOut !== 1'b1) begin
                n_fail++;
                $display("FAIL line_release: sdCmdOut=%b while sdCmdEn=0, expected 1", sdCmdOut);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdClk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89)
    function automatic logic [6:0] crc7(input logic [119:0] v, input int n);
        logic [126:0] r;
        r = {v, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7({80'h0, h}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] build_rsp(input logic [1:0] t, input logic [5:0] idx,
                                               input logic [127:0] d);
        logic [39:0] h;
        case (t)
            2'd1: begin
                h = {2'b00, idx, d[31:0]};
                return {h, crc7({80'h0, h}, 40), 1'b1, 88'h0};
            end
            2'd2:    return {2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1, 88'h0};
            2'd3:    return {2'b00, 6'h3F, d[127:8], crc7(d[127:8], 120), 1'b1};
            default: return '0;
        endcase
    endfunction

    function automatic int rsp_len(input logic [1:0] t);
        return (t == 2'd0) ? 0 : ((t == 2'd3) ? 136 : 48);
    endfunction

    // ---------------- drivers ----------------
    // Drives a frame MSB first; returns in cycle E+1
    task automatic send_frame(input logic [47:0] f, output bit early);
        early = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            sdCmdIn = f[i];
            tick();
            if (i > 0 && cmdValid) early = 1'b1;
        end
        sdCmdIn = 1'b1;
    endtask

    task automatic run_txn(input logic [47:0] frame, input bit exp_err,
                           input logic [5:0] exp_idx, input logic [31:0] exp_arg,
                           input logic [1:0] rtype, input logic [127:0] rdata,
                           input int dly, input bit withhold,
                           input logic [135:0] exp_rsp, input int exp_len);
        bit early, bad;
        int rel, start_rel, len, exp_start;
        logic [135:0] cap;
        send_frame(frame, early);
        chk("early_valid", early, 0);
        chk("cmdValid", cmdValid, 1);
        chk("cmdCrcErr", cmdCrcErr, exp_err);
        if (!exp_err) begin
            chk("cmdIndex", cmdIndex, exp_idx);
            chk("cmdArg", cmdArg, exp_arg);
        end
        if (exp_err) begin
            bad = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (rspReady || sdCmdEn || busy) bad = 1'b1;
                tick();
            end
            chk("no_rsp_after_err", bad, 0);
        end else if (withhold) begin
            rel = 1;
            bad = 1'b0;
            while (rel < NCR_MAX) begin
                if (rspTimeout || !rspReady || sdCmdEn) bad = 1'b1;
                tick();
                rel++;
            end
            chk("wait_window", bad, 0);
            chk("rspTimeout", rspTimeout, 1);
            chk("ready_drop", rspReady, 0);
            chk("busy_tmo", busy, 0);
            tick();
            chk("tmo_pulse", rspTimeout, 0);
            chk("tmo_line", sdCmdEn, 0);
        end else begin
            rel = 1;
            bad = 1'b0;
            for (int k = 0; k < dly; k++) begin
                if (!rspReady || sdCmdEn) bad = 1'b1;
                tick();
                rel++;
            end
            chk("ready_hold", bad, 0);
            chk("ready_at_hs", rspReady, 1);
            rspValid = 1'b1;
            rspType  = rtype;
            rspData  = rdata;
            tick();
            rel++;
            rspValid = 1'b0;
            rspType  = 2'($urandom);
            rspData  = {$urandom, $urandom, $urandom, $urandom};
            chk("ready_after_hs", rspReady, 0);
            if (rtype == 2'd0) begin
                chk("none_no_drive", sdCmdEn, 0);
                chk("none_busy", busy, 0);
            end else begin
                start_rel = -1;
                len = 0;
                cap = '0;
                for (int k = 0; k < 200 && (start_rel < 0 || sdCmdEn); k++) begin
                    if (sdCmdEn) begin
                        if (start_rel < 0) start_rel = rel;
                        if (len < 136) cap[135 - len] = sdCmdOut;
                        len++;
                    end
                    tick();
                    rel++;
                end
                exp_start = (NCR > 2 + dly) ? NCR : 2 + dly;
                chk("start_cycle", start_rel, exp_start);
                chk("en_len", len, exp_len);
                chk("rsp_frame", cap, exp_rsp);
                chk("busy_end", busy, 0);
                chk("idx_hold", cmdIndex, exp_idx);
            end
        end
        tick();
        tick();
    endtask

    typedef struct {
        string        name;
        logic [47:0]  frame;
        bit           exp_err;
        logic [5:0]   exp_idx;
        logic [31:0]  exp_arg;
        logic [1:0]   rtype;
        logic [127:0] rdata;
        int           dly;
        bit           withhold;
        logic [135:0] exp_rsp;
        int           exp_len;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit           early;
        logic [47:0]  f;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rt;
        logic [127:0] rd;
        bit           bad;

        tbl[0] = '{"cmd0", 48'h40_00000000_95, 0, 6'd0, 32'h0, 2'd0, 128'h0, 0, 0, 136'h0, 0};
        tbl[1] = '{"cmd8_r1", 48'h48_000001AA_87, 0, 6'd8, 32'h1AA, 2'd1, 128'h1AA, 0, 0,
                   {48'h08_000001AA_13, 88'h0}, 48};
        tbl[2] = '{"cmd8_badcrc", 48'h48_000001AA_85, 1, 6'd8, 32'h1AA, 2'd1, 128'h1AA, 0, 0,
                   136'h0, 0};
        tbl[3] = '{"cmd55_r1", 48'h77_00000000_65, 0, 6'd55, 32'h0, 2'd1, 128'h120, 2, 0,
                   build_rsp(2'd1, 6'd55, 128'h120), 48};
        tbl[4] = '{"acmd41_r3", make_cmd(6'd41, 32'h40FF8000), 0, 6'd41, 32'h40FF8000, 2'd2,
                   {96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'h80FF8000}, 1, 0,
                   {48'h3F_80FF8000_FF, 88'h0}, 48};
        tbl[5] = '{"cmd2_r2", 48'h42_00000000_4D, 0, 6'd2, 32'h0, 2'd3, 128'h0, 0, 0,
                   {8'h3F, 120'h0, 8'h01}, 136};
        tbl[6] = '{"cmd2_tmo", 48'h42_00000000_4D, 0, 6'd2, 32'h0, 2'd3, 128'h0, 0, 1,
                   136'h0, 0};

        // Reset state
        tag = "reset";
        tick();
        tick();
        chk("sdCmdEn", sdCmdEn, 0);
        chk("sdCmdOut", sdCmdOut, 1);
        chk("cmdValid", cmdValid, 0);
        chk("cmdIndex", cmdIndex, 0);
        chk("cmdArg", cmdArg, 0);
        chk("cmdCrcErr", cmdCrcErr, 0);
        chk("rspReady", rspReady, 0);
        chk("rspTimeout", rspTimeout, 0);
        chk("busy", busy, 0);
        sysRstN = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 7; i++) begin
            tag = tbl[i].name;
            run_txn(tbl[i].frame, tbl[i].exp_err, tbl[i].exp_idx, tbl[i].exp_arg,
                    tbl[i].rtype, tbl[i].rdata, tbl[i].dly, tbl[i].withhold,
                    tbl[i].exp_rsp, tbl[i].exp_len);
        end

        // Transmission bit 0: frame dropped silently
        tag = "txbit0";
        send_frame({2'b00, 46'h3FFF_FFFF_FFFF}, early);
        chk("early_valid", early, 0);
        chk("no_valid", cmdValid, 0);
        chk("busy", busy, 0);
        tick();
        tick();

        // Start bit on the cycle the state returns to IDLE is ignored
        tag = "dead_cycle";
        send_frame(48'h40_00000000_95, early);
        chk("cmdValid", cmdValid, 1);
        rspValid = 1'b1;
        rspType  = 2'd0;
        tick();
        rspValid = 1'b0;
        chk("idle", busy, 0);
        sdCmdIn = 1'b0;
        tick();
        sdCmdIn = 1'b1;
        chk("start_ignored", busy, 0);
        tick();
        chk("still_idle", busy, 0);
        tick();
        tag = "after_dead";
        run_txn(48'h48_000001AA_87, 0, 6'd8, 32'h1AA, 2'd1, 128'h1AA, 0, 0,
                {48'h08_000001AA_13, 88'h0}, 48);

        // Random transactions against the model
        for (int it = 0; it < 30; it++) begin
            tag = $sformatf("rand%0d", it);
            idx = 6'($urandom);
            arg = $urandom;
            f   = make_cmd(idx, arg);
            bad = ($urandom_range(0, 4) == 0);
            if (bad) f = f ^ (48'h1 << $urandom_range(0, 7));
            rt  = 2'($urandom);
            rd  = {$urandom, $urandom, $urandom, $urandom};
            run_txn(f, bad, idx, arg, rt, rd, $urandom_range(0, 4),
                    ($urandom_range(0, 7) == 0), build_rsp(rt, idx, rd), rsp_len(rt));
        end

        // Asynchronous reset in the middle of an R2 response
        tag = "reset_mid_tx";
        send_frame(48'h42_00000000_4D, early);
        rspValid = 1'b1;
        rspType  = 2'd3;
        rspData  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        rspValid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("driving", sdCmdEn, 1);
        #2;
        sysRstN = 1'b0;
        #1;
        chk("sdCmdEn", sdCmdEn, 0);
        chk("sdCmdOut", sdCmdOut, 1);
        chk("busy", busy, 0);
        chk("rspReady", rspReady, 0);
        chk("cmdIndex", cmdIndex, 0);
        @(posedge sdClk);
        #1;
        sysRstN = 1'b1;
        tick();
        tick();
        tag = "cmd0_after_reset";
        run_txn(48'h40_00000000_95, 0, 6'd0, 32'h0, 2'd0, 128'h0, 0, 0, 136'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side responder for the SD CMD line. It is the counterpart of the host command engine on sdClk.
- Deserializes 48-bit host command frames and checks framing and CRC7.
- Presents index and argument to local card logic.
- Serializes the 48-bit (R1/R3/R6/R7) or 136-bit (R2) response that local logic supplies, with correct NCR spacing.
- Used for loopback bring-up and self-test of the uSD host path on the board.

Parameters:
NCR, 2, minimum cycles from command end bit to response start bit (legal 2..NCR_MAX)
NCR_MAX, 64, cycles after end bit after which an unanswered command times out

Ports:
sdClk  in  1  SD clock; all logic on rising edge
sysRstN  in  1  asynchronous active-low reset
sdCmdIn  in  1  CMD line input, sampled on rising sdClk
sdCmdOut  out  1  CMD line drive value
sdCmdEn  out  1  CMD output enable, active high
cmdValid  out  1  one-cycle pulse: received command fields valid
cmdIndex  out  6  received command index
cmdArg  out  32  received argument
cmdCrcErr  out  1  qualifies cmdValid: CRC7 mismatch or end bit 0
rspReady  out  1  high in WAIT_RSP; response can be accepted
rspValid  in  1  response request; accepted when rspValid&rspReady
rspType  in  2  0 none, 1 R1-style (index echo, CRC computed), 2 R3 (index 6'h3F, CRC 7'h7F), 3 R2 136-bit
rspData  in  128  R1/R3: [31:0] payload; R2: CID/CSD [127:8], [7:0] ignored
rspTimeout  out  1  one-cycle pulse: no response accepted by NCR_MAX
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous, immediate, also mid-frame): sdCmdEn=0, sdCmdOut=1, cmdValid=0, cmdIndex=0, cmdArg=0, cmdCrcErr=0, rspReady=0, rspTimeout=0, busy=0, state IDLE.
- Whenever sdCmdEn=0, sdCmdOut=1.
- IDLE: when sdCmdIn=0 is sampled (start bit), go to RX. The bit counter counts the remaining 47 bits.
- RX:
  - Sampled bit 46 (transmission bit) must be 1. If it is 0, discard the frame silently: no cmdValid, return to IDLE.
  - Bits 45:40 are the index, 39:8 the argument, 7:1 the CRC, 0 the end bit.
  - The running CRC7 covers the start bit through argument bit 8 (40 bits).
  - CRC7 polynomial x^7+x^3+1, initial value 0, MSB first.
- Let E be the cycle in which the end bit is sampled.
  - cmdValid pulses in cycle E+1 with index, arg and cmdCrcErr.
  - cmdIndex and cmdArg hold until the next cmdValid.
- If cmdCrcErr=1: return to IDLE. No response is sent and rspReady never asserts.
- WAIT_RSP (entered at E+1 when CRC is OK): rspReady=1.
  - If the handshake occurs in cycle R, latch rspType/rspData. The start bit is driven in cycle max(E+NCR, R+1).
  - If rspType=0, return to IDLE without driving the line.
  - If no handshake by cycle E+NCR_MAX, rspTimeout pulses in that cycle, rspReady drops, and the state returns to IDLE.
- TX (48-bit): sends 0, 0, index, payload[31:0], CRC7, 1.
  - R1 index = latched cmdIndex; CRC7 computed over the first 40 bits.
  - R3 sends index 6'h3F and CRC 7'h7F.
- TX (R2): sends 0, 0, 6'h3F, rspData[127:8], CRC7, 1.
  - CRC7 is computed over rspData[127:8] (120 bits) and replaces [7:1].
- sdCmdEn=1 from the start bit through the end bit inclusive. It deasserts the cycle after the end bit; the state then returns to IDLE.
- sdCmdIn is ignored from E+1 until the return to IDLE, i.e. no start detection during WAIT_RSP or TX.
- A start bit sampled in the same cycle as the return to IDLE is not detected. The first detectable start bit is the following cycle.

Test Plan:
- CMD0 frame 0x40_00000000_95 -> cmdValid at E+1, cmdIndex=0, cmdArg=0, cmdCrcErr=0. Then rspType=0 -> line never driven, busy drops.
- CMD8 frame 0x48_000001AA_87, rspValid high at E+1 with rspType=1 and rspData[31:0]=0x000001AA -> start bit at E+2 and response bits 0x08_000001AA_13. sdCmdEn high exactly 48 cycles.
- CMD8 with CRC byte 0x85 -> cmdValid with cmdCrcErr=1, rspReady never asserts, sdCmdEn stays 0.
- CMD55 0x77_00000000_65, then ACMD41 0x69_40FF8000_xx, answered with rspType=2 and payload 0x80FF8000 -> response 0x3F_80FF8000_FF.
- CMD2 answered with R2 and rspData[127:8]=120'h0 -> 136-bit frame 0, 0, 3F, 120 zero bits, CRC7=0x00, end 1. Repeat with rspValid withheld -> rspTimeout at E+64 and line stays released.
- Frame with transmission bit 0 -> no cmdValid. Also: sysRstN low mid-TX -> sdCmdEn=0 and sdCmdOut=1 immediately; a CMD0 after release decodes correctly.
